// File: rtl/encoder16x4_arb.sv
// 16-to-4 priority encoder with a pending-request register and a valid/ack handshake.
// Requests are latched so short pulses survive; one index is granted at a time.
module encoder16x4_arb #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] req,
    input  logic        ack,
    output logic [3:0]  code,
    output logic        valid,
    output logic [4:0]  npend
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pend;
    logic [15:0] w_pend_nxt;
    logic [15:0] w_new;
    logic [15:0] w_cand;
    logic [15:0] w_clr;
    logic [3:0]  r_code;
    logic [3:0]  w_code_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic [4:0]  r_npend;

    function automatic logic [3:0] prio_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        if (HIGH_FIRST) begin
            // Ascending scan: the last hit is the highest set bit.
            for (int i = 0; i < 16; i++)
                if (v[i]) idx = 4'(i);
        end else begin
            for (int i = 15; i >= 0; i--)
                if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++)
            cnt = cnt + {4'd0, v[i]};
        return cnt;
    endfunction

    assign w_new  = en ? req : 16'd0;
    assign w_cand = r_pend | w_new;

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_valid_nxt = r_valid;
        w_clr       = 16'd0;
        case (r_state)
            S_IDLE: begin
                if (w_cand != 16'd0) begin
                    w_code_nxt  = prio_idx(w_cand);
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (ack) begin
                    w_clr       = 16'd1 << r_code;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A new request on the bit being acknowledged survives the clear.
        w_pend_nxt = (r_pend & ~w_clr) | w_new;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pend  <= 16'd0;
            r_code  <= 4'd0;
            r_valid <= 1'b0;
            r_npend <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
            r_npend <= popcount16(w_pend_nxt);
        end
    end

    assign code  = r_code;
    assign valid = r_valid;
    assign npend = r_npend;

endmodule

// File: tb/tb_encoder16x4_arb.sv
// Directed bench for encoder16x4_arb: handshake, priority order, hold, merge and reset.
module tb_encoder16x4_arb;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic        ack;
    logic [3:0]  code;
    logic        valid;
    logic [4:0]  npend;
    logic [3:0]  code_lo;
    logic        valid_lo;
    logic [4:0]  npend_lo;

    int checks;
    int failures;

    encoder16x4_arb #(.HIGH_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
        .code(code), .valid(valid), .npend(npend)
    );

    encoder16x4_arb #(.HIGH_FIRST(1'b0)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
        .code(code_lo), .valid(valid_lo), .npend(npend_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; req = 16'd0; ack = 1'b0;
        step(); step();
        checks++;
        if (valid !== 1'b0 || code !== 4'd0 || npend !== 5'd0) begin
            failures++;
            $display("FAIL reset_held: valid=%b code=%0d npend=%0d want 0/0/0", valid, code, npend);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (valid !== 1'b0 || code !== 4'd0 || npend !== 5'd0) begin
                failures++;
                $display("FAIL reset_idle[%0d]: valid=%b code=%0d npend=%0d want 0/0/0", i, valid, code, npend);
            end
        end
    endtask

    task automatic test_single;
        req = 16'h0020; ack = 1'b1;
        step();
        req = 16'd0;
        checks++;
        if (valid !== 1'b1 || code !== 4'd5 || npend !== 5'd1) begin
            failures++;
            $display("FAIL single_grant: valid=%b code=%0d npend=%0d want 1/5/1", valid, code, npend);
        end
        step();
        checks++;
        if (valid !== 1'b0 || npend !== 5'd0) begin
            failures++;
            $display("FAIL single_clear: valid=%b npend=%0d want 0/0", valid, npend);
        end
        ack = 1'b0;
    endtask

    task automatic test_priority;
        logic [3:0] exp_hi [3];
        logic [3:0] exp_lo [3];
        logic [4:0] exp_np [3];
        exp_hi = '{4'd15, 4'd2, 4'd0};
        exp_lo = '{4'd0, 4'd2, 4'd15};
        exp_np = '{5'd3, 5'd2, 5'd1};
        req = 16'h8005; ack = 1'b1;
        for (int g = 0; g < 3; g++) begin
            step();
            req = 16'd0;
            checks++;
            if (valid !== 1'b1 || code !== exp_hi[g] || npend !== exp_np[g]) begin
                failures++;
                $display("FAIL prio_hi[%0d]: valid=%b code=%0d npend=%0d want 1/%0d/%0d",
                         g, valid, code, npend, exp_hi[g], exp_np[g]);
            end
            checks++;
            if (valid_lo !== 1'b1 || code_lo !== exp_lo[g] || npend_lo !== exp_np[g]) begin
                failures++;
                $display("FAIL prio_lo[%0d]: valid=%b code=%0d npend=%0d want 1/%0d/%0d",
                         g, valid_lo, code_lo, npend_lo, exp_lo[g], exp_np[g]);
            end
            step();
            checks++;
            if (valid !== 1'b0 || npend !== exp_np[g] - 5'd1) begin
                failures++;
                $display("FAIL prio_bubble[%0d]: valid=%b npend=%0d want 0/%0d",
                         g, valid, npend, exp_np[g] - 5'd1);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_hold;
        req = 16'h0008; ack = 1'b0;
        step();
        req = 16'd0;
        checks++;
        if (valid !== 1'b1 || code !== 4'd3) begin
            failures++;
            $display("FAIL hold_grant: valid=%b code=%0d want 1/3", valid, code);
        end
        for (int i = 0; i < 10; i++) begin
            req = (i == 3) ? 16'h0100 : 16'd0;
            step();
            checks++;
            if (valid !== 1'b1 || code !== 4'd3) begin
                failures++;
                $display("FAIL hold_stable[%0d]: valid=%b code=%0d want 1/3", i, valid, code);
            end
        end
        req = 16'd0;
        checks++;
        if (npend !== 5'd2) begin
            failures++;
            $display("FAIL hold_npend: npend=%0d want 2", npend);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || npend !== 5'd1) begin
            failures++;
            $display("FAIL hold_bubble: valid=%b npend=%0d want 0/1", valid, npend);
        end
        step();
        checks++;
        if (valid !== 1'b1 || code !== 4'd8) begin
            failures++;
            $display("FAIL hold_next: valid=%b code=%0d want 1/8", valid, code);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || npend !== 5'd0) begin
            failures++;
            $display("FAIL hold_drain: valid=%b npend=%0d want 0/0", valid, npend);
        end
    endtask

    task automatic test_ack_req_same_bit;
        req = 16'h0080; ack = 1'b0;
        step();
        req = 16'd0;
        checks++;
        if (valid !== 1'b1 || code !== 4'd7) begin
            failures++;
            $display("FAIL same_grant: valid=%b code=%0d want 1/7", valid, code);
        end
        req = 16'h0080; ack = 1'b1;
        step();
        req = 16'd0; ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || npend !== 5'd1) begin
            failures++;
            $display("FAIL same_keep: valid=%b npend=%0d want 0/1", valid, npend);
        end
        step();
        checks++;
        if (valid !== 1'b1 || code !== 4'd7 || npend !== 5'd1) begin
            failures++;
            $display("FAIL same_regrant: valid=%b code=%0d npend=%0d want 1/7/1", valid, code, npend);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || npend !== 5'd0) begin
            failures++;
            $display("FAIL same_drain: valid=%b npend=%0d want 0/0", valid, npend);
        end
    endtask

    task automatic test_en_and_idle_ack;
        en = 1'b0; req = 16'hFFFF; ack = 1'b1;
        step(); step();
        checks++;
        if (valid !== 1'b0 || npend !== 5'd0) begin
            failures++;
            $display("FAIL en_block: valid=%b npend=%0d want 0/0", valid, npend);
        end
        en = 1'b1; req = 16'h0003; ack = 1'b0;
        step();
        en = 1'b0; req = 16'd0;
        checks++;
        if (valid !== 1'b1 || code !== 4'd1 || npend !== 5'd2) begin
            failures++;
            $display("FAIL en_grant: valid=%b code=%0d npend=%0d want 1/1/2", valid, code, npend);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        checks++;
        if (valid !== 1'b1 || code !== 4'd0 || npend !== 5'd1) begin
            failures++;
            $display("FAIL en_serve: valid=%b code=%0d npend=%0d want 1/0/1", valid, code, npend);
        end
        ack = 1'b1;
        step();
        ack = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset_mid_grant;
        req = 16'h0003; ack = 1'b0;
        step();
        req = 16'd0;
        checks++;
        if (valid !== 1'b1 || code !== 4'd1 || npend !== 5'd2) begin
            failures++;
            $display("FAIL rstmid_pre: valid=%b code=%0d npend=%0d want 1/1/2", valid, code, npend);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0 || code !== 4'd0 || npend !== 5'd0) begin
            failures++;
            $display("FAIL rstmid_async: valid=%b code=%0d npend=%0d want 0/0/0", valid, code, npend);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (valid !== 1'b0 || npend !== 5'd0) begin
                failures++;
                $display("FAIL rstmid_after[%0d]: valid=%b npend=%0d want 0/0", i, valid, npend);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_priority();
        test_hold();
        test_ack_req_same_bit();
        test_en_and_idle_ack();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
